fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32i_types.sv | 21 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types used across the pipeline.
// Adds the fetch state encoding and the fetch buffer entry.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word inst;
    } fetch_entry_t;

    localparam int FETCH_DEPTH = 2;
    localparam rv32i_word PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer between instruction memory and decode.
// Head at entry 0; pop shifts entry 1 down; flush empties it.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent [DEPTH];
    logic         wr_idx;

    // Slot for an incoming entry after any same-cycle pop.
    assign wr_idx = count[0] ^ pop;

    // Empty buffer presents zeros at the head.
    assign head = (count == 2'd0) ? '0 : ent[0];

    // Entry storage and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                ent[0] <= ent[1];
            end
            if (push) begin
                ent[wr_idx] <= din;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, 2-entry buffer.
// Define FETCH_BYPASS_EN to forward a response straight to decode.
module fetch_unit
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h00000060,
    parameter int        DEPTH    = FETCH_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    output logic      inst_read,
    output rv32i_word inst_addr,
    input  logic      inst_resp,
    input  rv32i_word inst_rdata,
    input  logic      redirect,
    input  rv32i_word redirect_pc,
    input  logic      stall,
    output logic      if_valid,
    output rv32i_word if_pc,
    output rv32i_word if_inst
);

    fetch_state_t state;
    rv32i_word    fetch_pc;
    rv32i_word    next_pc;
    rv32i_word    target_pc;
    fetch_entry_t head;
    fetch_entry_t din;
    logic [1:0]   count;
    logic [1:0]   post_cnt;
    logic         resp_ok;
    logic         bypass;
    logic         push;
    logic         pop;

    assign next_pc   = fetch_pc + PC_STEP;
    assign target_pc = redirect_pc & ~32'h3;
    assign resp_ok   = (state == WAIT) && inst_resp && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_ok && (count == 2'd0) && !stall;
`else
    assign bypass = 1'b0;
`endif

    assign push     = resp_ok && !bypass;
    assign pop      = (count != 2'd0) && !stall;
    assign post_cnt = count + {1'b0, push} - {1'b0, pop};
    assign din      = '{pc: fetch_pc, inst: inst_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );

    // Decode view: buffer head, or the live response when bypassing.
    always_comb begin
        if_valid = (count != 2'd0);
        if_pc    = head.pc;
        if_inst  = head.inst;
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            if_valid = 1'b1;
            if_pc    = fetch_pc;
            if_inst  = inst_rdata;
        end
`endif
    end

    // Request FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            inst_read <= 1'b0;
            inst_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end else if (count < 2'd2) begin
                        state     <= WAIT;
                        inst_read <= 1'b1;
                        inst_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                        if (inst_resp) begin
                            state     <= IDLE;
                            inst_read <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (inst_resp) begin
                        fetch_pc <= next_pc;
                        if (post_cnt < 2'd2) begin
                            inst_addr <= next_pc;
                        end else begin
                            state     <= IDLE;
                            inst_read <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= target_pc;
                    end
                    if (inst_resp) begin
                        state     <= IDLE;
                        inst_read <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    inst_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit.
// Inputs change on the falling edge; outputs checked 1ns later.
module tb_fetch_unit;
    import rv32i_types::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      inst_read;
    rv32i_word inst_addr;
    logic      inst_resp = 1'b0;
    rv32i_word inst_rdata = '0;
    logic      redirect = 1'b0;
    rv32i_word redirect_pc = '0;
    logic      stall = 1'b0;
    logic      if_valid;
    rv32i_word if_pc;
    rv32i_word if_inst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic      resp;
        rv32i_word rdata;
        logic      redir;
        rv32i_word rpc;
        logic      stl;
        logic      e_read;
        rv32i_word e_addr;
        logic      e_valid;
        rv32i_word e_pc;
        rv32i_word e_inst;
    } vec_t;

    vec_t tbl [18];
    vec_t sq  [10];

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_read   (inst_read),
        .inst_addr   (inst_addr),
        .inst_resp   (inst_resp),
        .inst_rdata  (inst_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic resp, input rv32i_word rdata,
        input logic redir, input rv32i_word rpc, input logic stl,
        input logic e_read, input rv32i_word e_addr,
        input logic e_valid, input rv32i_word e_pc,
        input rv32i_word e_inst);
        vec_t v;
        v.resp = resp;   v.rdata = rdata;
        v.redir = redir; v.rpc = rpc;
        v.stl = stl;
        v.e_read = e_read;   v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_inst = e_inst;
        return v;
    endfunction

    task automatic chk(input string nm, input rv32i_word act,
                       input rv32i_word exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and compare before the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        inst_resp   = v.resp;
        inst_rdata  = v.rdata;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        stall       = v.stl;
        #1;
        chk({tag, ".read"}, {31'd0, inst_read}, {31'd0, v.e_read});
        if (v.e_read) chk({tag, ".addr"}, inst_addr, v.e_addr);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v.e_valid});
        chk({tag, ".pc"}, if_pc, v.e_pc);
        chk({tag, ".inst"}, if_inst, v.e_inst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        inst_resp = 1'b0;
        redirect  = 1'b0;
        stall     = 1'b0;
        #1;
        chk({tag, ".rst_read"}, {31'd0, inst_read}, 32'd0);
        chk({tag, ".rst_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, ".rst_pc"}, if_pc, 32'd0);
        chk({tag, ".rst_inst"}, if_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_seq(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            run_vec(sq[i], $sformatf("%s%0d", tag, i));
        end
    endtask

    initial begin
        // Sequential fetch, then stall saturation and resume.
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 32'h60, 0, 0, 0);
        tbl[2]  = mk(1, 32'hA0, 0, 0, 1, 1, 32'h60, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'h64, 1, 32'h60, 32'hA0);
        tbl[4]  = mk(1, 32'hA1, 0, 0, 1, 1, 32'h64, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 32'h68, 1, 32'h64, 32'hA1);
        tbl[6]  = mk(1, 32'hA2, 0, 0, 1, 1, 32'h68, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 32'h6C, 1, 32'h68, 32'hA2);
        tbl[8]  = mk(1, 32'hA3, 0, 0, 1, 1, 32'h6C, 1, 32'h68, 32'hA2);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h68, 32'hA2);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h68, 32'hA2);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h68, 32'hA2);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h68, 32'hA2);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h68, 32'hA2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h6C, 32'hA3);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 32'h70, 0, 0, 0);
        tbl[16] = mk(1, 32'hA4, 0, 0, 1, 1, 32'h70, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 32'h74, 1, 32'h70, 32'hA4);

        do_reset("main");
        for (int i = 0; i < 18; i++) begin
            run_vec(tbl[i], $sformatf("main%0d", i));
        end

        // Redirect while waiting: old request completes, data dropped.
        sq[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[1] = mk(0, 0, 0, 0, 0, 1, 32'h60, 0, 0, 0);
        sq[2] = mk(1, 32'hA0, 0, 0, 1, 1, 32'h60, 0, 0, 0);
        sq[3] = mk(0, 0, 1, 32'h200, 0, 1, 32'h64, 1, 32'h60, 32'hA0);
        sq[4] = mk(0, 0, 0, 0, 0, 1, 32'h64, 0, 0, 0);
        sq[5] = mk(1, 32'hDEAD, 0, 0, 0, 1, 32'h64, 0, 0, 0);
        sq[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[7] = mk(1, 32'hB0, 0, 0, 1, 1, 32'h200, 0, 0, 0);
        sq[8] = mk(0, 0, 0, 0, 0, 1, 32'h204, 1, 32'h200, 32'hB0);
        do_reset("disc");
        run_seq(9, "disc");

        // Redirect with response, then unaligned redirect and wrap.
        sq[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[1] = mk(0, 0, 0, 0, 0, 1, 32'h60, 0, 0, 0);
        sq[2] = mk(1, 32'hA0, 1, 32'h1000, 0, 1, 32'h60, 0, 0, 0);
        sq[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[4] = mk(0, 0, 1, 32'hFFFFFFFE, 0, 1, 32'h1000, 0, 0, 0);
        sq[5] = mk(1, 32'hBAD, 0, 0, 0, 1, 32'h1000, 0, 0, 0);
        sq[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[7] = mk(0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
        sq[8] = mk(1, 32'hE0, 0, 0, 1, 1, 32'hFFFFFFFC, 0, 0, 0);
        sq[9] = mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFFFFFC, 32'hE0);
        do_reset("wrap");
        run_seq(10, "wrap");

        // Reset mid-request; late response in IDLE is ignored.
        sq[0] = mk(1, 32'hBAD, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[1] = mk(0, 0, 0, 0, 0, 1, 32'h60, 0, 0, 0);
        sq[2] = mk(0, 0, 0, 0, 0, 1, 32'h60, 0, 0, 0);
        do_reset("late");
        run_seq(3, "late");

        // Response into empty buffer with and without stall.
        sq[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq[1] = mk(1, 32'h11, 0, 0, 0, 1, 32'h60,
                   BYP, BYP ? 32'h60 : 32'h0, BYP ? 32'h11 : 32'h0);
        sq[2] = mk(0, 0, 0, 0, 0, 1, 32'h64,
                   !BYP, BYP ? 32'h0 : 32'h60, BYP ? 32'h0 : 32'h11);
        sq[3] = mk(1, 32'h22, 0, 0, 1, 1, 32'h64, 0, 0, 0);
        sq[4] = mk(0, 0, 0, 0, 0, 1, 32'h68, 1, 32'h64, 32'h22);
        do_reset("byp");
        run_seq(5, "byp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
